// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 1 start bit, DBIT data bits LSB first, optional parity, stop bits.
// Define UART_RX_PARITY_EN to add a parity bit after the data (PARITY_ODD selects its sense).
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] SMid  = SW'(7);
  localparam logic [SW-1:0] SBit  = SW'(15);
  localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rx_s_q, rx_q;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   rx_dout_q, rx_dout_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;

`ifdef UART_RX_PARITY_EN
  localparam logic OddSense = (PARITY_ODD != 0);
  logic p_q, p_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = ^PARITY_ODD;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_q         <= 1'b1;
      state_q      <= StIdle;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      rx_dout_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q          <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_q         <= rx_s_q;
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      rx_dout_q    <= rx_dout_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      p_q          <= p_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    rx_dout_d    = rx_dout_q;
    rx_done_d    = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
`ifdef UART_RX_PARITY_EN
    p_d          = p_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Only a high-to-low transition starts a frame, so a stuck-low line cannot retrigger.
        if (rx_q && !rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SMid) begin
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SBit) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (s_tick) begin
          if (s_q == SBit) begin
            p_d     = rx_s_q;
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      StStop: begin
        if (s_tick) begin
          if (s_q == SStop) begin
            state_d     = StIdle;
            rx_done_d   = 1'b1;
            rx_dout_d   = b_q;
            frame_err_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ((^b_q) ^ p_q) != OddSense;
`else
            parity_err_d = 1'b0;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_dout      = rx_dout_q;
  assign rx_done_tick = rx_done_q;
  assign frame_err    = frame_err_q;
  assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 100 MHz clk, s_tick every 54 clk, DBIT=8, one stop bit.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int TickDiv = 54;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  int tests_run  = 0;
  int fails      = 0;
  int strobe_cnt = 0;
  int tick_div   = 0;

  // Entries are {parity_err, frame_err, rx_dout}.
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  uart_rx #(
    .DBIT      (8),
    .SB_TICK   (16),
    .PARITY_ODD(0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .rx_dout     (rx_dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick_div == TickDiv - 1) begin
      tick_div <= 0;
      s_tick   <= 1'b1;
    end else begin
      tick_div <= tick_div + 1;
      s_tick   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      obs_q.push_back({parity_err, frame_err, rx_dout});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      do @(negedge clk); while (s_tick !== 1'b1);
    end
  endtask

  task automatic get_obs(output logic [9:0] o, output bit ok);
    ok = 1'b0;
    o  = 'x;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (obs_q.size() > 0) begin
        o  = obs_q.pop_front();
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d;
    wait_ticks(16);
`endif
    rx = stop_v;
    wait_ticks(16);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rx_dout !== 8'h00) begin
      fails++;
      $display("FAIL reset_dout: got %h want 00", rx_dout);
    end
    tests_run++;
    if ({rx_done_tick, frame_err, parity_err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000", {rx_done_tick, frame_err, parity_err});
    end
    reset = 1'b0;
    wait_ticks(4);
    @(posedge clk);
    tests_run++;
    if (strobe_cnt != 0) begin
      fails++;
      $display("FAIL reset_idle_strobes: got %0d want 0", strobe_cnt);
    end
  endtask

  task automatic test_good_frame();
    int c0 = strobe_cnt;
    logic [9:0] e, o;
    bit ok;
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL good_frame: got %h (seen=%0d) want %h", o, ok, e);
      end
    end
    @(posedge clk);
    tests_run++;
    if (strobe_cnt - c0 != 1) begin
      fails++;
      $display("FAIL good_frame_strobes: got %0d want 1", strobe_cnt - c0);
    end
  endtask

  task automatic test_glitch();
    int c0 = strobe_cnt;
    logic [9:0] e, o;
    bit ok;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(16);
    @(posedge clk);
    tests_run++;
    if (strobe_cnt != c0) begin
      fails++;
      $display("FAIL glitch_strobes: got %0d want 0", strobe_cnt - c0);
    end
    tests_run++;
    if (rx_dout !== 8'hA5) begin
      fails++;
      $display("FAIL glitch_hold: got %h want a5", rx_dout);
    end
    exp_q.push_back({2'b00, 8'h3C});
    send_frame(8'h3C, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL glitch_next_frame: got %h (seen=%0d) want %h", o, ok, e);
      end
    end
  endtask

  task automatic test_frame_err_break();
    int c0 = strobe_cnt;
    logic [9:0] e, o;
    bit ok;
    exp_q.push_back({2'b01, 8'h0F});
    send_frame(8'h0F, 1'b0);
    wait_ticks(320);
    rx = 1'b1;
    wait_ticks(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL frame_err: got %h (seen=%0d) want %h", o, ok, e);
      end
    end
    @(posedge clk);
    tests_run++;
    if (strobe_cnt - c0 != 1) begin
      fails++;
      $display("FAIL break_strobes: got %0d want 1", strobe_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0 = strobe_cnt;
    logic [7:0] d = 8'h81;
    logic [9:0] e, o;
    bit ok;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[4];
    wait_ticks(8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    tests_run++;
    if ({parity_err, frame_err, rx_done_tick, rx_dout} !== 11'h000) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h want 000",
               {parity_err, frame_err, rx_done_tick, rx_dout});
    end
    wait_ticks(32);
    @(posedge clk);
    tests_run++;
    if (strobe_cnt != c0) begin
      fails++;
      $display("FAIL reset_mid_strobes: got %0d want 0", strobe_cnt - c0);
    end
    exp_q.push_back({2'b00, 8'h7E});
    send_frame(8'h7E, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL reset_next_frame: got %h (seen=%0d) want %h", o, ok, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0 = strobe_cnt;
    logic [7:0] frames[3] = '{8'h00, 8'hFF, 8'h55};
    logic [9:0] e, o;
    bit ok;
    foreach (frames[i]) begin
      exp_q.push_back({2'b00, frames[i]});
      send_frame(frames[i], 1'b1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL back_to_back: got %h (seen=%0d) want %h", o, ok, e);
      end
    end
    @(posedge clk);
    tests_run++;
    if (strobe_cnt - c0 != 3) begin
      fails++;
      $display("FAIL back_to_back_strobes: got %0d want 3", strobe_cnt - c0);
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_outputs: got %0d extra want 0", obs_q.size());
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic p);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = p;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
  endtask

  task automatic test_parity();
    logic [9:0] e, o;
    bit ok;
    exp_q.push_back({2'b00, 8'h07});
    send_par_frame(8'h07, 1'b1);
    exp_q.push_back({2'b10, 8'h07});
    send_par_frame(8'h07, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      tests_run++;
      if (!ok || o !== e) begin
        fails++;
        $display("FAIL parity: got %h (seen=%0d) want %h", o, ok, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err_break();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
